trigger_arbiter: RTL and testbench

Sequencing controller for the trigger board's firing path. Takes the per-trigger condition levels, the enable mask, the run gate and the prescale decision, and grants one firing at a time. For each firing it:
- drives the common output pulse;
- gathers every trigger that qualifies inside a short window into one bitmask;
- enforces a global dead time;
- queues a {mask, timestamp} record in an 8-deep FIFO for readout on the same clock.

---
 rtl/trig_pkg.sv | 31 +++
 rtl/trigger_arbiter_if.sv | 15 +
 rtl/trig_rec_fifo.sv | 67 ++++++
 rtl/trigger_arbiter.sv | 138 +++++++++++++
 tb/tb_trigger_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/trig_pkg.sv
// Shared types and sizes for the trigger arbiter.
//   N_TRIG/TS_W/DEPTH : trigger count, timestamp width, record FIFO depth
//   trig_rec_t        : one queued firing record {mask, timestamp}
//   arb_state_t       : firing sequencer states
package trig_pkg;

  localparam int unsigned N_TRIG  = 8;
  localparam int unsigned TS_W    = 56;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned ADDR_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W   = ADDR_W + 1;
  localparam int unsigned CNT_W   = PTR_W;
  localparam int unsigned WIN_W   = 4;
  localparam int unsigned DEAD_W  = 8;
  localparam int unsigned PULSE_W = 6;
  localparam int unsigned OVF_W   = 16;

  // "time" is reserved in SystemVerilog, so the timestamp field is named ts
  typedef struct packed {
    logic [N_TRIG-1:0] mask;
    logic [TS_W-1:0]   ts;
  } trig_rec_t;

  typedef enum logic [1:0] {
    IDLE,
    GATHER,
    COMMIT,
    HOLDOFF
  } arb_state_t;

endpackage

// File: rtl/trigger_arbiter_if.sv
// Record readout handshake.
//   rec_valid/rec_mask/rec_time : FIFO head, driven by the arbiter (master)
//   rec_ready                   : consumer pop request (slave)
interface trigger_arbiter_if;
  import trig_pkg::*;

  logic              rec_valid;
  logic [N_TRIG-1:0] rec_mask;
  logic [TS_W-1:0]   rec_time;
  logic              rec_ready;

  modport master (output rec_valid, output rec_mask, output rec_time, input rec_ready);
  modport slave  (input rec_valid, input rec_mask, input rec_time, output rec_ready);

endinterface

// File: rtl/trig_rec_fifo.sv
// First-word-fall-through record FIFO with registered head.
//   clk_adc, reset : clock, synchronous active-high reset
//   clear          : synchronous flush (overrides push/pop)
//   wr_en/wr_data  : push request; accepted when not full or popping
//   rd_en          : pop request; ignored while empty
//   rd_data/rd_valid : registered head record and non-empty flag
//   full_c         : full flag decoded from count
//   count          : occupancy 0..DEPTH
module trig_rec_fifo
  import trig_pkg::*;
(
  input  logic             clk_adc,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_en,
  input  trig_rec_t        wr_data,
  input  logic             rd_en,
  output trig_rec_t        rd_data,
  output logic             rd_valid,
  output logic             full_c,
  output logic [CNT_W-1:0] count
);

  trig_rec_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_n;
  logic [CNT_W-1:0] count_n;
  logic             push_c;
  logic             pop_c;
  trig_rec_t        head_n;

  // Handshake qualification and next head selection
  always_comb begin
    full_c   = (count == CNT_W'(DEPTH));
    pop_c    = rd_en && rd_valid;
    push_c   = wr_en && (!full_c || pop_c);
    rd_ptr_n = rd_ptr + PTR_W'(pop_c);
    count_n  = count + CNT_W'(push_c) - CNT_W'(pop_c);
    // Pointers only match when the FIFO drains to empty; a same-cycle push is the new head
    if (push_c && (wr_ptr == rd_ptr_n)) head_n = wr_data;
    else                                head_n = mem[rd_ptr_n[ADDR_W-1:0]];
  end

  // Storage array, no reset needed
  always_ff @(posedge clk_adc) begin
    if (!reset && !clear && push_c) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

  // Pointers, occupancy and registered head
  always_ff @(posedge clk_adc) begin
    if (reset || clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_ptr   <= wr_ptr + PTR_W'(push_c);
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      rd_valid <= (count_n != '0);
      rd_data  <= (count_n != '0) ? head_n : '0;
    end
  end

endmodule

// File: rtl/trigger_arbiter.sv
// Firing sequencer: accepts one qualified trigger at a time, gathers
// coincident triggers into a mask, enforces dead time, drives the output
// pulse and queues {mask, timestamp} records for readout.
//   clk_adc, reset      : clock, synchronous active-high reset
//   trig_req/trig_enable: per-trigger level and enable
//   run_enable, pass_prescale : firing gates
//   dead_time, gather_len, out_width : timing controls
//   timestamp           : free-running time counter
//   clear               : flush FIFO and overflow count
//   fire_out, busy      : output pulse, sequencer non-idle
//   rec                 : record readout handshake
//   fifo_count, overflow_count : occupancy and dropped records
module trigger_arbiter
  import trig_pkg::*;
(
  input  logic                clk_adc,
  input  logic                reset,
  input  logic [N_TRIG-1:0]   trig_req,
  input  logic [N_TRIG-1:0]   trig_enable,
  input  logic                run_enable,
  input  logic                pass_prescale,
  input  logic [DEAD_W-1:0]   dead_time,
  input  logic [WIN_W-1:0]    gather_len,
  input  logic [PULSE_W-1:0]  out_width,
  input  logic [TS_W-1:0]     timestamp,
  input  logic                clear,
  output logic                fire_out,
  output logic                busy,
  output logic [CNT_W-1:0]    fifo_count,
  output logic [OVF_W-1:0]    overflow_count,
  trigger_arbiter_if.master   rec
);

  arb_state_t          state;
  arb_state_t          state_n;
  logic [N_TRIG-1:0]   mask;
  logic [TS_W-1:0]     ts;
  logic [WIN_W-1:0]    win;
  logic [DEAD_W-1:0]   dead;
  logic [PULSE_W-1:0]  pulse;
  logic [N_TRIG-1:0]   qual_c;
  logic                accept_c;
  logic                dead_done_c;
  logic                commit_c;
  logic                pop_c;
  logic                fifo_full_c;
  logic                overflow_c;
  trig_rec_t           push_rec_c;
  trig_rec_t           head;

  // State register
  always_ff @(posedge clk_adc) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and qualification
  always_comb begin
    qual_c      = trig_req & trig_enable;
    accept_c    = 1'b0;
    // dead reaches zero on the coming edge, so leaving now lands in IDLE on time
    dead_done_c = (dead <= DEAD_W'(1));
    state_n     = state;
    case (state)
      IDLE: begin
        accept_c = run_enable && pass_prescale && (|qual_c);
        if (accept_c) state_n = GATHER;
      end
      GATHER:  if (win == '0) state_n = COMMIT;
      COMMIT:  state_n = dead_done_c ? IDLE : HOLDOFF;
      HOLDOFF: if (dead_done_c) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    commit_c    = (state == COMMIT);
    pop_c       = rec.rec_valid && rec.rec_ready;
    overflow_c  = commit_c && !clear && fifo_full_c && !pop_c;
    push_rec_c  = '{mask: mask, ts: ts};
  end

  // Firing datapath: mask/timestamp capture, window, dead time, pulse
  always_ff @(posedge clk_adc) begin
    if (reset) begin
      busy     <= 1'b0;
      mask     <= '0;
      ts       <= '0;
      win      <= '0;
      dead     <= '0;
      pulse    <= '0;
      fire_out <= 1'b0;
    end else begin
      busy <= (state_n != IDLE);
      if (accept_c) begin
        mask <= qual_c;
        ts   <= timestamp;
        win  <= gather_len;
        dead <= dead_time;
      end else begin
        if (state == GATHER) begin
          if (run_enable) mask <= mask | qual_c;
          if (win != '0)  win  <= win - WIN_W'(1);
        end
        if (dead != '0) dead <= dead - DEAD_W'(1);
      end
      // pulse holds the cycles remaining after the current one
      if (accept_c) begin
        fire_out <= 1'b1;
        pulse    <= (out_width == '0) ? '0 : out_width - PULSE_W'(1);
      end else if (pulse != '0) begin
        pulse <= pulse - PULSE_W'(1);
      end else begin
        fire_out <= 1'b0;
      end
    end
  end

  // Saturating dropped-record counter
  always_ff @(posedge clk_adc) begin
    if (reset || clear)                            overflow_count <= '0;
    else if (overflow_c && (overflow_count != '1)) overflow_count <= overflow_count + OVF_W'(1);
  end

  trig_rec_fifo u_fifo (
    .clk_adc  (clk_adc),
    .reset    (reset),
    .clear    (clear),
    .wr_en    (commit_c),
    .wr_data  (push_rec_c),
    .rd_en    (rec.rec_ready),
    .rd_data  (head),
    .rd_valid (rec.rec_valid),
    .full_c   (fifo_full_c),
    .count    (fifo_count)
  );

  assign rec.rec_mask = head.mask;
  assign rec.rec_time = head.ts;

endmodule

// File: tb/tb_trigger_arbiter.sv
// Directed self-checking bench for trigger_arbiter.
module tb_trigger_arbiter;
  import trig_pkg::*;

  logic               clk_adc;
  logic               reset;
  logic [N_TRIG-1:0]  trig_req;
  logic [N_TRIG-1:0]  trig_enable;
  logic               run_enable;
  logic               pass_prescale;
  logic [7:0]         dead_time;
  logic [3:0]         gather_len;
  logic [5:0]         out_width;
  logic [TS_W-1:0]    timestamp;
  logic               clear;
  logic               fire_out;
  logic               busy;
  logic [3:0]         fifo_count;
  logic [15:0]        overflow_count;

  trigger_arbiter_if rec_bus ();

  trigger_arbiter dut (
    .clk_adc        (clk_adc),
    .reset          (reset),
    .trig_req       (trig_req),
    .trig_enable    (trig_enable),
    .run_enable     (run_enable),
    .pass_prescale  (pass_prescale),
    .dead_time      (dead_time),
    .gather_len     (gather_len),
    .out_width      (out_width),
    .timestamp      (timestamp),
    .clear          (clear),
    .fire_out       (fire_out),
    .busy           (busy),
    .fifo_count     (fifo_count),
    .overflow_count (overflow_count),
    .rec            (rec_bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0;
  int t11;
  int ts_q [10];

  initial clk_adc = 1'b0;
  always #5 clk_adc = ~clk_adc;

  // Advance one cycle; outputs are read 1 time unit after the edge
  task automatic tick();
    @(posedge clk_adc);
    #1;
    cyc = cyc + 1;
    timestamp = TS_W'(cyc);
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks = checks + 1;
    assert (observed === expected)
    else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Check head record then pop it
  task automatic pop_check(input string tag, input logic [7:0] m, input int t);
    check({tag, "_valid"}, 64'(rec_bus.rec_valid), 64'd1);
    check({tag, "_mask"},  64'(rec_bus.rec_mask), 64'(m));
    check({tag, "_time"},  64'(rec_bus.rec_time), 64'(t));
    rec_bus.rec_ready = 1'b1;
    tick();
    rec_bus.rec_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; trig_req = '0; trig_enable = '1; run_enable = 1'b1;
    pass_prescale = 1'b1; dead_time = 8'd10; gather_len = 4'd2; out_width = 6'd4;
    timestamp = '0; clear = 1'b0; rec_bus.rec_ready = 1'b0;
    tickn(2);
    reset = 1'b0;

    // Reset state
    check("rst_fire",  64'(fire_out), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_valid", 64'(rec_bus.rec_valid), 64'd0);
    check("rst_mask",  64'(rec_bus.rec_mask), 64'd0);
    check("rst_time",  64'(rec_bus.rec_time), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_ovf",   64'(overflow_count), 64'd0);
    tickn(2);

    // Single firing: pulse t+1..t+4, record at t+5, next accept at t+11
    t0 = cyc; trig_req = 8'h01;
    tick(); trig_req = '0;
    check("single_fire_t1", 64'(fire_out), 64'd1);
    check("single_busy_t1", 64'(busy), 64'd1);
    tickn(3);
    check("single_fire_t4",  64'(fire_out), 64'd1);
    check("single_valid_t4", 64'(rec_bus.rec_valid), 64'd0);
    tick();
    check("single_fire_t5",  64'(fire_out), 64'd0);
    check("single_valid_t5", 64'(rec_bus.rec_valid), 64'd1);
    check("single_mask_t5",  64'(rec_bus.rec_mask), 64'h01);
    check("single_time_t5",  64'(rec_bus.rec_time), 64'(t0));
    check("single_count_t5", 64'(fifo_count), 64'd1);
    trig_req = 8'h01;
    tickn(5);
    check("holdoff_fire_t10", 64'(fire_out), 64'd0);
    check("holdoff_busy_t10", 64'(busy), 64'd1);
    tick();
    check("holdoff_fire_t11", 64'(fire_out), 64'd0);
    check("holdoff_busy_t11", 64'(busy), 64'd0);
    tick(); trig_req = '0;
    check("refire_t12", 64'(fire_out), 64'd1);
    tickn(20);
    check("single_count2", 64'(fifo_count), 64'd2);
    pop_check("single_r0", 8'h01, t0);
    pop_check("single_r1", 8'h01, t0 + 11);
    check("single_drained", 64'(rec_bus.rec_valid), 64'd0);

    // Gathering: trig0@t, trig3@t+2 in window, trig5@t+4 outside
    t0 = cyc; trig_req = 8'h01;
    tick(); trig_req = '0;
    tick(); trig_req = 8'h08;
    tick(); trig_req = '0;
    tick(); trig_req = 8'h20;
    tick();
    check("gather_mask", 64'(rec_bus.rec_mask), 64'h09);
    tickn(6);
    check("gather_t5_blocked", 64'(fire_out), 64'd0);
    tick(); trig_req = '0;
    check("gather_t5_fire", 64'(fire_out), 64'd1);
    tickn(20);
    pop_check("gather_r0", 8'h09, t0);
    pop_check("gather_r1", 8'h20, t0 + 11);

    // Gating: prescale, run gate, enable mask
    pass_prescale = 1'b0; trig_req = 8'hFF;
    tickn(4);
    check("gate_ps_fire", 64'(fire_out), 64'd0);
    check("gate_ps_busy", 64'(busy), 64'd0);
    pass_prescale = 1'b1; run_enable = 1'b0;
    tickn(4);
    check("gate_run_fire", 64'(fire_out), 64'd0);
    check("gate_run_busy", 64'(busy), 64'd0);
    run_enable = 1'b1; trig_enable = 8'h00;
    tickn(4);
    check("gate_en_fire",  64'(fire_out), 64'd0);
    check("gate_en_busy",  64'(busy), 64'd0);
    trig_req = '0; trig_enable = '1;
    tick();
    check("gate_no_record", 64'(rec_bus.rec_valid), 64'd0);

    // Overflow: 10 firings with no readout
    for (int i = 0; i < 10; i++) begin
      ts_q[i] = cyc; trig_req = 8'h01;
      tick(); trig_req = '0;
      tickn(10);
    end
    check("ovf_count", 64'(fifo_count), 64'd8);
    check("ovf_ovf",   64'(overflow_count), 64'd2);
    check("ovf_head",  64'(rec_bus.rec_time), 64'(ts_q[0]));

    // Commit while full with a pop in the same cycle
    t11 = cyc; trig_req = 8'h01;
    tick(); trig_req = '0;
    tickn(3);
    rec_bus.rec_ready = 1'b1;
    tick();
    rec_bus.rec_ready = 1'b0;
    check("fullpop_count", 64'(fifo_count), 64'd8);
    check("fullpop_ovf",   64'(overflow_count), 64'd2);
    for (int i = 1; i < 8; i++) pop_check("drain", 8'h01, ts_q[i]);
    pop_check("drain_last", 8'h01, t11);
    check("drain_empty", 64'(fifo_count), 64'd0);
    tickn(4);

    // Clear during COMMIT
    trig_req = 8'h01;
    tick(); trig_req = '0;
    tickn(3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_count", 64'(fifo_count), 64'd0);
    check("clear_ovf",   64'(overflow_count), 64'd0);
    tickn(3);
    check("clear_valid", 64'(rec_bus.rec_valid), 64'd0);
    tickn(10);

    // out_width 0 behaves as 1
    out_width = 6'd0; t0 = cyc; trig_req = 8'h01;
    tick(); trig_req = '0;
    check("ow0_fire_t1", 64'(fire_out), 64'd1);
    tick();
    check("ow0_fire_t2", 64'(fire_out), 64'd0);
    out_width = 6'd4;
    tickn(12);
    pop_check("ow0_rec", 8'h01, t0);

    // Reset mid-GATHER aborts the record
    trig_req = 8'h01;
    tick(); trig_req = '0; reset = 1'b1;
    tick(); reset = 1'b0;
    check("rstg_busy",  64'(busy), 64'd0);
    check("rstg_fire",  64'(fire_out), 64'd0);
    check("rstg_valid", 64'(rec_bus.rec_valid), 64'd0);
    tickn(8);
    check("rstg_norec", 64'(fifo_count), 64'd0);
    check("rstg_idle",  64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
